// File: rtl/smpte_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// smpte_pattern_gen_pkg
// Shared definitions for the SMPTE pattern stage:
//   - band_e  : vertical band of the three-band pattern (TOP/MID/BOT)
//   - mode_e  : selectable output pattern
//   - LUT_*   : per-bar rgb rows, 3 bits per bar, bar 0 in the LSBs
//   - lookup_rgb : mode/band/bar -> {r,g,b}
// -----------------------------------------------------------------------------
package smpte_pattern_gen_pkg;

  typedef enum logic [1:0] {
    BAND_TOP = 2'd0,
    BAND_MID = 2'd1,
    BAND_BOT = 2'd2
  } band_e;

  typedef enum logic [1:0] {
    MODE_SMPTE = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_WHITE = 2'd2,
    MODE_BLANK = 2'd3
  } mode_e;

  // Rows are padded to 8 entries (bar 7 = black) so any 3-bit index is in range.
  //                               bar7    bar6    bar5    bar4    bar3    bar2    bar1    bar0
  localparam logic [23:0] LUT_TOP = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
  localparam logic [23:0] LUT_MID = {3'b000, 3'b111, 3'b000, 3'b011, 3'b000, 3'b101, 3'b000, 3'b001};
  localparam logic [23:0] LUT_BOT = {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b111, 3'b001};

  function automatic logic [2:0] lookup_rgb(input mode_e mode, input band_e band,
                                            input logic [2:0] bar);
    logic [23:0] row;
    logic [4:0]  base;
    logic [2:0]  rgb;
    row  = LUT_TOP;
    base = 5'(bar) * 5'd3;
    case (band)
      BAND_MID: row = LUT_MID;
      BAND_BOT: row = LUT_BOT;
      default:  row = LUT_TOP;
    endcase
    case (mode)
      MODE_SMPTE: rgb = row[base +: 3];
      MODE_BARS:  rgb = LUT_TOP[base +: 3];
      MODE_WHITE: rgb = 3'b111;
      default:    rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/smpte_pattern_gen_btn_sync_edge.sv
// -----------------------------------------------------------------------------
// smpte_pattern_gen_btn_sync_edge
// Two-flop synchroniser for an asynchronous active-high button followed by an
// edge register; emits a one-clock pulse on each rising edge of the
// synchronised level.
//   clk       : destination clock
//   reset     : synchronous active-high reset (clears all flops)
//   btn_async : raw button input
//   pulse     : one-cycle rising-edge strobe
// -----------------------------------------------------------------------------
module smpte_pattern_gen_btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_async,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/smpte_pattern_gen.sv
// -----------------------------------------------------------------------------
// smpte_pattern_gen
// Turns scan-timing signals into 1-bit-per-gun RGB test patterns with a fixed
// two-clock latency on every video output.
//   clk, reset            : pixel clock, synchronous active-high reset
//   hpos, vpos            : scan position from the timing generator
//   display_on            : visible-region flag
//   hsync_in, vsync_in    : syncs from the timing generator
//   mode_btn              : asynchronous pattern-select button
//   rgb                   : registered {r,g,b}
//   hsync_out, vsync_out  : syncs delayed to line up with rgb
//   display_out           : display flag delayed to line up with rgb
//   frame_led             : toggles every FRAME_DIV frames
//   mode                  : pattern currently shown
// -----------------------------------------------------------------------------
module smpte_pattern_gen #(
  parameter int H_DISPLAY       = 256,
  parameter int BAR_WIDTH       = 36,
  parameter int V_TOP           = 160,
  parameter int V_MID           = 180,
  parameter int FRAME_DIV       = 30,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       mode_btn,
  output logic [2:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       display_out,
  output logic       frame_led,
  output logic [1:0] mode
);

  import smpte_pattern_gen_pkg::*;

  localparam logic       SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);
  localparam logic [8:0] H_LIM      = 9'(H_DISPLAY);
  localparam logic [8:0] V_TOP_L    = 9'(V_TOP);
  localparam logic [8:0] V_MID_L    = 9'(V_MID);
  localparam logic [5:0] PX_LAST    = 6'(BAR_WIDTH - 1);
  localparam logic [2:0] BAR_LAST   = 3'd6;
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_DIV - 1);

  // Bar counter
  logic [5:0] px_cnt_q,  px_cnt_d;
  logic [2:0] bar_idx_q, bar_idx_d;
  // Stage 1
  band_e      band1_q,   band1_d;
  logic [2:0] bar1_q,    bar1_d;
  logic       disp1_q,   disp1_d;
  logic       hs1_q,     hs1_d;
  logic       vs1_q,     vs1_d;
  // Stage 2
  logic [2:0] rgb_q,     rgb_d;
  logic       disp2_q,   disp2_d;
  logic       hs2_q,     hs2_d;
  logic       vs2_q,     vs2_d;
  // Frame / mode control
  logic       vs_prev_q, vs_prev_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       led_q,     led_d;
  mode_e      mode_q,    mode_d;
  logic       pend_q,    pend_d;

  logic       pixel_valid;
  logic       frame_boundary;
  logic       btn_pulse;

  smpte_pattern_gen_btn_sync_edge u_btn_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .btn_async (mode_btn),
    .pulse     (btn_pulse)
  );

  // Bar position is counted from the start of the displayed run rather than
  // decoded from hpos; hpos only guards against an over-long display window.
  always_comb begin
    pixel_valid = display_on && (hpos < H_LIM);
    px_cnt_d    = px_cnt_q;
    bar_idx_d   = bar_idx_q;
    if (!pixel_valid) begin
      px_cnt_d  = 6'd0;
      bar_idx_d = 3'd0;
    end else if ((px_cnt_q == PX_LAST) && (bar_idx_q < BAR_LAST)) begin
      px_cnt_d  = 6'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      px_cnt_d  = px_cnt_q + 6'd1;
    end
  end

  // Stage 1 captures the current pixel's attributes; stage 2 does the lookup.
  always_comb begin
    band1_d = BAND_BOT;
    if (vpos < V_TOP_L) begin
      band1_d = BAND_TOP;
    end else if (vpos < V_MID_L) begin
      band1_d = BAND_MID;
    end
    bar1_d  = bar_idx_q;
    disp1_d = pixel_valid;
    hs1_d   = hsync_in;
    vs1_d   = vsync_in;

    rgb_d   = disp1_q ? lookup_rgb(mode_q, band1_q, bar1_q) : 3'b000;
    disp2_d = disp1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
  end

  // Mode changes are deferred to the start of vsync so a frame never tears.
  // A pending flag (not a counter) means extra presses within a frame collapse.
  always_comb begin
    frame_boundary = (vsync_in == ~SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);
    vs_prev_d      = vsync_in;
    mode_d         = mode_q;
    pend_d         = pend_q;
    frame_cnt_d    = frame_cnt_q;
    led_d          = led_q;
    if (frame_boundary) begin
      if (pend_q || btn_pulse) begin
        mode_d = mode_e'(mode_q + 2'd1);
      end
      pend_d = 1'b0;
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = 5'd0;
        led_d       = ~led_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 5'd1;
      end
    end else if (btn_pulse) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px_cnt_q    <= 6'd0;
      bar_idx_q   <= 3'd0;
      band1_q     <= BAND_TOP;
      bar1_q      <= 3'd0;
      disp1_q     <= 1'b0;
      hs1_q       <= SYNC_IDLE;
      vs1_q       <= SYNC_IDLE;
      rgb_q       <= 3'b000;
      disp2_q     <= 1'b0;
      hs2_q       <= SYNC_IDLE;
      vs2_q       <= SYNC_IDLE;
      vs_prev_q   <= SYNC_IDLE;
      frame_cnt_q <= 5'd0;
      led_q       <= 1'b0;
      mode_q      <= MODE_SMPTE;
      pend_q      <= 1'b0;
    end else begin
      px_cnt_q    <= px_cnt_d;
      bar_idx_q   <= bar_idx_d;
      band1_q     <= band1_d;
      bar1_q      <= bar1_d;
      disp1_q     <= disp1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      rgb_q       <= rgb_d;
      disp2_q     <= disp2_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign display_out = disp2_q;
  assign frame_led   = led_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_smpte_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_smpte_pattern_gen
// Drives scan lines and frames with randomised vpos, display windows and button
// presses; a behavioural model predicts every output each clock.
// -----------------------------------------------------------------------------
module tb_smpte_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] hpos = 9'd0;
  logic [8:0] vpos = 9'd0;
  logic       display_on = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       mode_btn = 1'b0;
  logic [2:0] rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic       display_out;
  logic       frame_led;
  logic [1:0] mode;

  always #5 clk = ~clk;

  smpte_pattern_gen dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .mode_btn    (mode_btn),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .display_out (display_out),
    .frame_led   (frame_led),
    .mode        (mode)
  );

  int total = 0;
  int bad   = 0;

  // Pattern rows as listed for bars 0..6.
  int top_t [7] = '{7, 6, 3, 2, 5, 4, 1};
  int mid_t [7] = '{1, 0, 5, 0, 3, 0, 7};
  int bot_t [7] = '{1, 7, 5, 0, 0, 0, 0};

  // Reference model state
  bit s1_disp;
  int s1_band;
  int s1_bar;
  bit s1_hs;
  bit s1_vs;
  int o_rgb;
  bit o_hs;
  bit o_vs;
  bit o_disp;
  int m_mode;
  int m_fcnt;
  int run;
  bit m_pend;
  bit m_led;
  bit m_vsprev;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lut(input int md, input int band, input int bar);
    if (md == 3) return 0;
    if (md == 2) return 7;
    if (md == 1) return top_t[bar];
    if (band == 0) return top_t[bar];
    if (band == 1) return mid_t[bar];
    return bot_t[bar];
  endfunction

  task automatic model_reset();
    s1_disp = 0; s1_band = 0; s1_bar = 0; s1_hs = 1; s1_vs = 1;
    o_rgb = 0; o_hs = 1; o_vs = 1; o_disp = 0;
    m_mode = 0; m_fcnt = 0; run = 0; m_pend = 0; m_led = 0; m_vsprev = 1;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare every output shortly after the edge.
  task automatic tick();
    bit valid;
    bit boundary;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      o_rgb  = s1_disp ? lut(m_mode, s1_band, s1_bar) : 0;
      o_hs   = s1_hs;
      o_vs   = s1_vs;
      o_disp = s1_disp;
      valid   = display_on && (int'(hpos) < 256);
      s1_disp = valid;
      s1_band = (vpos < 160) ? 0 : ((vpos < 180) ? 1 : 2);
      s1_bar  = (run / 36 > 6) ? 6 : run / 36;
      run     = valid ? run + 1 : 0;
      s1_hs   = hsync_in;
      s1_vs   = vsync_in;
      boundary = !vsync_in && m_vsprev;
      m_vsprev = vsync_in;
      if (boundary) begin
        if (m_pend) m_mode = (m_mode + 1) % 4;
        m_pend = 0;
        m_fcnt++;
        if (m_fcnt == 30) begin
          m_fcnt = 0;
          m_led  = ~m_led;
        end
      end
    end
    #1;
    check("rgb",         rgb,         8'(o_rgb));
    check("hsync_out",   hsync_out,   8'(o_hs));
    check("vsync_out",   vsync_out,   8'(o_vs));
    check("display_out", display_out, 8'(o_disp));
    check("mode",        mode,        8'(m_mode));
    check("frame_led",   frame_led,   8'(m_led));
  endtask

  // One 320-clock line. p1/p2: button press columns (-1 = none);
  // rst_col: column at which reset is pulsed (-1 = none).
  task automatic do_line(input int vp, input int disp_end, input bit vs_line,
                         input int p1, input int p2, input int rst_col);
    for (int c = 0; c < 320; c++) begin
      hpos       = 9'(c);
      vpos       = 9'(vp);
      display_on = (c < disp_end) && !((rst_col >= 0) && (c >= rst_col));
      hsync_in   = !((c >= 280) && (c < 300));
      vsync_in   = vs_line ? !((c >= 10) && (c < 60)) : 1'b1;
      mode_btn   = ((p1 >= 0) && (c >= p1) && (c < p1 + 4)) ||
                   ((p2 >= 0) && (c >= p2) && (c < p2 + 4));
      if ((c == p1) || (c == p2)) m_pend = 1;
      reset      = (c == rst_col);
      tick();
      if (c == rst_col) begin
        check("rst_mid_rgb",   rgb,         8'd0);
        check("rst_mid_hs",    hsync_out,   8'd1);
        check("rst_mid_vs",    vsync_out,   8'd1);
        check("rst_mid_disp",  display_out, 8'd0);
        check("rst_mid_mode",  mode,        8'd0);
        check("rst_mid_led",   frame_led,   8'd0);
      end
    end
    reset    = 1'b0;
    mode_btn = 1'b0;
  endtask

  initial begin
    int sel [3] = '{10, 170, 200};
    int vp;
    int de;
    int p1;
    int p2;
    int rc;
    int r;

    model_reset();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_rgb",  rgb,       8'd0);
    check("rst_hs",   hsync_out, 8'd1);
    check("rst_vs",   vsync_out, 8'd1);
    check("rst_mode", mode,      8'd0);
    check("rst_led",  frame_led, 8'd0);
    reset = 1'b0;

    // Directed lines: TOP, MID, BOT in mode 0.
    do_line(10,  256, 1'b0, -1, -1, -1);
    do_line(170, 256, 1'b0, -1, -1, -1);
    do_line(200, 256, 1'b0, -1, -1, -1);

    // Frames: vsync line followed by three visible lines.
    for (int f = 0; f < 14; f++) begin
      do_line(240, 0, 1'b1, -1, -1, -1);
      if (f <= 4) check("mode_frame", mode, 8'(f % 4));
      if (f == 5) check("mode_double", mode, 8'd1);
      for (int ln = 0; ln < 3; ln++) begin
        vp = (ln == 0) ? sel[f % 3] : int'($urandom_range(0, 239));
        de = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 290)) : 256;
        p1 = -1; p2 = -1; rc = -1;
        if (ln == 1) begin
          if (f < 4) begin
            p1 = int'($urandom_range(20, 200));
          end else if (f == 4) begin
            p1 = int'($urandom_range(20, 100));
            p2 = p1 + int'($urandom_range(30, 100));
          end else begin
            r = int'($urandom_range(0, 5));
            if (r < 2) p1 = int'($urandom_range(20, 150));
            if (r == 0) p2 = p1 + int'($urandom_range(30, 100));
          end
        end
        if ((f == 8) && (ln == 2)) begin
          de = 256; rc = 118; vp = 20;
        end
        do_line(vp, de, 1'b0, p1, p2, rc);
      end
    end

    // Fast frames for the LED divider: 61 vsync assertions after a reset.
    reset = 1'b1;
    display_on = 1'b0;
    hpos = 9'd0;
    vsync_in = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 61; i++) begin
      vsync_in = 1'b0;
      repeat (3) tick();
      vsync_in = 1'b1;
      repeat (7) tick();
      if (i == 28) check("led_before_30", frame_led, 8'd0);
      if (i == 29) check("led_after_30",  frame_led, 8'd1);
      if (i == 59) check("led_after_60",  frame_led, 8'd0);
    end
    check("led_end", frame_led, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smpte_pattern_gen.md
Name: smpte_pattern_gen

Overview:
- Pixel-pattern stage directly downstream of the scan timing generator.
- Consumes hpos/vpos/display_on/hsync/vsync and produces registered 1-bit-per-gun RGB plus re-aligned syncs for the video connector.
- Pattern options: full three-band SMPTE pattern, full-height bars, solid white or blank, selected by a debounced-edge mode button.
- Also drives the 1 Hz frame-activity LED, derived synchronously in the pixel clock domain.

Parameters:
- H_DISPLAY, 256, visible pixels per line.
- BAR_WIDTH, 36, pixels in bars 0..5; bar 6 takes the remainder (H_DISPLAY-6*BAR_WIDTH = 40).
- V_TOP, 160, first row of the middle band.
- V_MID, 180, first row of the bottom band.
- FRAME_DIV, 30, frames per LED toggle.
- SYNC_ACTIVE_LOW, 1, sync polarity of the inputs and outputs.

Ports:
- clk  in  1  pixel clock (the divided 6 MHz clock).
- reset  in  1  synchronous, active-high reset.
- hpos  in  9  horizontal position from the timing generator.
- vpos  in  9  vertical position from the timing generator.
- display_on  in  1  visible-region flag.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator.
- mode_btn  in  1  asynchronous pushbutton, active-high.
- rgb  out  3  {r,g,b}, registered.
- hsync_out  out  1  hsync delayed to align with rgb.
- vsync_out  out  1  vsync delayed to align with rgb.
- display_out  out  1  display_on delayed to align with rgb.
- frame_led  out  1  toggles every FRAME_DIV frames.
- mode  out  2  current pattern mode.

Behaviour:
- One clock domain. All state updates on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - rgb=0, display_out=0, frame_led=0, mode=0.
  - hsync_out and vsync_out at the inactive level (1 when SYNC_ACTIVE_LOW).
  - All counters, pipeline registers and synchronisers cleared to 0; sync pipeline registers cleared to the inactive level.
- Bar counter (px_cnt 6b, bar_idx 3b):
  - When display_on=0: both forced to 0.
  - When display_on=1: px_cnt increments each clock. When px_cnt==BAR_WIDTH-1 and bar_idx<6: bar_idx increments and px_cnt returns to 0.
  - bar_idx saturates at 6. In bar 6, px_cnt keeps counting and does not wrap bar_idx.
  - hpos is used only for the sanity check hpos<H_DISPLAY. Pixels with hpos>=H_DISPLAY are treated as not displayed.
- Band decode: vpos<V_TOP gives TOP; vpos<V_MID gives MID; otherwise BOT.
- Pipeline:
  - Stage 1 registers bar_idx, band, the display flag and both syncs.
  - Stage 2 registers rgb from the lookup, gated by the stage-1 display flag, and passes the syncs and display flag through.
  - Latency is exactly 2 clocks from inputs to all outputs.
- Lookup, mode 0 (rgb per bar 0..6):
  - TOP: 111,110,011,010,101,100,001.
  - MID: 001,000,101,000,011,000,111.
  - BOT: bar0=001, bar1=111, bar2=101, bars3..6=000.
- Other modes:
  - Mode 1: the TOP row for all vpos.
  - Mode 2: 111 whenever displayed.
  - Mode 3: 000.
- Mode button path:
  - 2-FF synchroniser, then an edge register.
  - A rising edge of the synchronised level advances mode (3 wraps to 0).
  - The mode change takes effect at the next frame boundary, so no mid-frame tearing; the pending request is held until then.
  - A second press before that boundary does not queue a further step.
- Frame boundary is the clock on which vsync_in transitions to its active level, detected by a registered previous sample.
- LED counter:
  - frame_cnt (5b) increments on each frame boundary.
  - At frame_cnt==FRAME_DIV-1 on a frame boundary: frame_cnt returns to 0 and frame_led toggles.
- Pending mode request coinciding with a frame boundary: the mode is applied on that same clock.
- Reset mid-frame: outputs return to reset values on the next clock and the pending request is dropped. The first frame boundary after reset counts as frame 1.

Decomposition:
- Shared package holds:
  - band encoding (TOP=0, MID=1, BOT=2);
  - mode encoding (0..3);
  - the three 7-entry rgb lookup constants.
- Natural sub-module: btn_sync_edge, the 2-FF synchroniser plus rising-edge pulse, reused for future buttons.

Test Plan:
- Reset, then a full line with display_on high and vpos=10 → rgb sequence begins exactly 2 clocks after display_on rises:
  - 36×111, 36×110, 36×011, 36×010, 36×101, 36×100, then 40×001;
  - display_out aligned with the rgb output.
- vpos=170 and vpos=200 lines in mode 0 → MID and BOT patterns as specified, rgb=000 throughout blanking, syncs delayed by exactly 2 clocks.
- Drive 61 vsync assertions → frame_led toggles after frames 30 and 60, ending at 0.
- Pulse mode_btn mid-frame → mode stays 0 until the next vsync assertion, then becomes 1. Four presses across four frames → mode back to 0.
- Two presses within one frame → mode advances by exactly 1.
- Assert reset mid-line during bar 3 → next clock: rgb=0, hsync_out/vsync_out=1, mode=0, frame_led=0. The next line restarts at bar 0.
